// File: rtl/regfile_sb_if.sv
// Register-file / scoreboard bundle: read ports, writeback, issue and
// hazard/busy status. The issuer drives through the master modport.
interface regfile_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            rd_en;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [XLEN-1:0] rso1;
    logic [XLEN-1:0] rso2;
    logic            wb_en;
    logic [AW-1:0]   wb_reg;
    logic [XLEN-1:0] wb_val;
    logic            iss_en;
    logic [AW-1:0]   iss_rd;
    logic            hazard;
    logic [AW:0]     busy_cnt;

    modport master (
        output rd_en, rs1, rs2, wb_en, wb_reg, wb_val, iss_en, iss_rd,
        input  rso1, rso2, hazard, busy_cnt
    );

    modport slave (
        input  rd_en, rs1, rs2, wb_en, wb_reg, wb_val, iss_en, iss_rd,
        output rso1, rso2, hazard, busy_cnt
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: two-read/one-write register file with a per-register busy
// scoreboard. Register 0 is hard-wired to zero and never becomes busy.
// Optional macro REGFILE_SB_BYPASS_EN: same-edge writeback is forwarded to
// the read ports (write-first) and masks the busy bit being retired from
// the hazard output. Without it, reads are read-first and hazard uses the
// raw busy bits.
module regfile_sb #(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic        clk,
    input  logic        rst,
    regfile_sb_if.slave bus
);

    localparam logic [AW-1:0] REG_ZERO = {AW{1'b0}};

    logic [XLEN-1:0] regs_r [NREG];
    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_nxt_s;
    logic [NREG-1:0] busy_eff_s;
    logic [AW:0]     busy_cnt_r;
    logic [XLEN-1:0] rso1_r;
    logic [XLEN-1:0] rso2_r;
    logic [XLEN-1:0] rd1_s;
    logic [XLEN-1:0] rd2_s;
    logic            hazard_s;

    function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
        logic [AW:0] c;
        c = {(AW+1){1'b0}};
        for (int i = 0; i < NREG; i++) begin
            c = c + {{AW{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Next busy vector: writeback clears, issue sets afterwards so set wins.
    always_comb begin
        busy_nxt_s = busy_r;
        if (bus.wb_en) begin
            busy_nxt_s[bus.wb_reg] = 1'b0;
        end else begin
            busy_nxt_s = busy_r;
        end
        if (bus.iss_en && (bus.iss_rd != REG_ZERO)) begin
            busy_nxt_s[bus.iss_rd] = 1'b1;
        end else begin
            busy_nxt_s[0] = 1'b0;
        end
        busy_nxt_s[0] = 1'b0;
    end

`ifdef REGFILE_SB_BYPASS_EN
    // Busy view for hazard: a register retiring this cycle is no longer a
    // hazard unless it is being re-issued at the same edge.
    always_comb begin
        busy_eff_s = busy_r;
        if (bus.wb_en && !(bus.iss_en && (bus.iss_rd == bus.wb_reg))) begin
            busy_eff_s[bus.wb_reg] = 1'b0;
        end else begin
            busy_eff_s = busy_r;
        end
    end

    // Read data with write-first forwarding of the same-edge writeback.
    always_comb begin
        rd1_s = regs_r[bus.rs1];
        rd2_s = regs_r[bus.rs2];
        if (bus.wb_en && (bus.wb_reg == bus.rs1) && (bus.rs1 != REG_ZERO)) begin
            rd1_s = bus.wb_val;
        end else begin
            rd1_s = regs_r[bus.rs1];
        end
        if (bus.wb_en && (bus.wb_reg == bus.rs2) && (bus.rs2 != REG_ZERO)) begin
            rd2_s = bus.wb_val;
        end else begin
            rd2_s = regs_r[bus.rs2];
        end
    end
`else
    // Hazard uses the raw busy bits.
    always_comb begin
        busy_eff_s = busy_r;
    end

    // Read-first: the array value before this edge's writeback.
    always_comb begin
        rd1_s = regs_r[bus.rs1];
        rd2_s = regs_r[bus.rs2];
    end
`endif

    // Hazard: pending operand or pending destination; forced low in reset.
    always_comb begin
        hazard_s = 1'b0;
        if (rst) begin
            hazard_s = busy_eff_s[bus.rs1] | busy_eff_s[bus.rs2]
                     | (bus.iss_en & busy_eff_s[bus.iss_rd]);
        end else begin
            hazard_s = 1'b0;
        end
    end

    // Register array: register 0 is never written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (bus.wb_en && (bus.wb_reg != REG_ZERO)) begin
            regs_r[bus.wb_reg] <= bus.wb_val;
        end
    end

    // Registered read ports, updated only when rd_en is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rso1_r <= {XLEN{1'b0}};
            rso2_r <= {XLEN{1'b0}};
        end else if (bus.rd_en) begin
            rso1_r <= rd1_s;
            rso2_r <= rd2_s;
        end
    end

    // Scoreboard state and its registered population count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r     <= {NREG{1'b0}};
            busy_cnt_r <= {(AW+1){1'b0}};
        end else begin
            busy_r     <= busy_nxt_s;
            busy_cnt_r <= popcount(busy_nxt_s);
        end
    end

    assign bus.rso1     = rso1_r;
    assign bus.rso2     = rso2_r;
    assign bus.busy_cnt = busy_cnt_r;
    assign bus.hazard   = hazard_s;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (XLEN=32, NREG=32).
module tb_regfile_sb;

`ifdef REGFILE_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    regfile_sb_if #(.XLEN(32), .AW(5)) bus ();

    regfile_sb #(.XLEN(32), .NREG(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic idle();
        bus.rd_en  = 1'b0;
        bus.rs1    = 5'd0;
        bus.rs2    = 5'd0;
        bus.wb_en  = 1'b0;
        bus.wb_reg = 5'd0;
        bus.wb_val = 32'h0;
        bus.iss_en = 1'b0;
        bus.iss_rd = 5'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        #2;
        n_checks++; if (bus.rso1 !== 32'h0) begin n_fail++; $display("FAIL rst_rso1: got %h exp %h", bus.rso1, 32'h0); end
        n_checks++; if (bus.rso2 !== 32'h0) begin n_fail++; $display("FAIL rst_rso2: got %h exp %h", bus.rso2, 32'h0); end
        n_checks++; if (bus.busy_cnt !== 6'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d exp 0", bus.busy_cnt); end
        n_checks++; if (bus.hazard !== 1'b0) begin n_fail++; $display("FAIL rst_hazard: got %b exp 0", bus.hazard); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            bus.rd_en = 1'b1;
            bus.rs1   = 5'(i);
            bus.rs2   = 5'(31 - i);
            tick();
            n_checks++; if (bus.rso1 !== 32'h0) begin n_fail++; $display("FAIL rst_read1 x%0d: got %h exp 0", i, bus.rso1); end
            n_checks++; if (bus.rso2 !== 32'h0) begin n_fail++; $display("FAIL rst_read2 x%0d: got %h exp 0", 31 - i, bus.rso2); end
        end
        idle();
        n_checks++; if (bus.busy_cnt !== 6'd0) begin n_fail++; $display("FAIL rst_cnt_after: got %0d exp 0", bus.busy_cnt); end
    endtask

    task automatic test_write_read();
        idle();
        bus.wb_en = 1'b1; bus.wb_reg = 5'd5; bus.wb_val = 32'hDEADBEEF;
        tick();
        idle();
        bus.rd_en = 1'b1; bus.rs1 = 5'd5;
        tick();
        n_checks++; if (bus.rso1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_x5: got %h exp %h", bus.rso1, 32'hDEADBEEF); end
        n_checks++; if (bus.rso2 !== 32'h0) begin n_fail++; $display("FAIL rd_x0_port2: got %h exp 0", bus.rso2); end
        idle();
        bus.wb_en = 1'b1; bus.wb_reg = 5'd0; bus.wb_val = 32'h1234;
        tick();
        idle();
        bus.rd_en = 1'b1; bus.rs1 = 5'd0; bus.rs2 = 5'd5;
        tick();
        n_checks++; if (bus.rso1 !== 32'h0) begin n_fail++; $display("FAIL wr_x0: got %h exp 0", bus.rso1); end
        n_checks++; if (bus.rso2 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_x5_port2: got %h exp %h", bus.rso2, 32'hDEADBEEF); end
        idle();
        bus.rs1 = 5'd5; bus.rs2 = 5'd0;
        tick();
        n_checks++; if (bus.rso1 !== 32'h0) begin n_fail++; $display("FAIL hold_rso1: got %h exp 0", bus.rso1); end
        n_checks++; if (bus.rso2 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hold_rso2: got %h exp %h", bus.rso2, 32'hDEADBEEF); end
    endtask

    task automatic test_scoreboard();
        idle();
        bus.iss_en = 1'b1; bus.iss_rd = 5'd7;
        #1;
        n_checks++; if (bus.hazard !== 1'b0) begin n_fail++; $display("FAIL iss7_nohaz: got %b exp 0", bus.hazard); end
        tick();
        idle();
        n_checks++; if (bus.busy_cnt !== 6'd1) begin n_fail++; $display("FAIL iss7_cnt: got %0d exp 1", bus.busy_cnt); end
        bus.rs2 = 5'd7;
        #1;
        n_checks++; if (bus.hazard !== 1'b1) begin n_fail++; $display("FAIL rs2_7_haz: got %b exp 1", bus.hazard); end
        bus.wb_en = 1'b1; bus.wb_reg = 5'd7; bus.wb_val = 32'h55;
        #1;
        n_checks++; if (bus.hazard !== !BYP) begin n_fail++; $display("FAIL wb7_haz_pre: got %b exp %b", bus.hazard, !BYP); end
        tick();
        idle();
        bus.rd_en = 1'b1; bus.rs2 = 5'd7;
        #1;
        n_checks++; if (bus.hazard !== 1'b0) begin n_fail++; $display("FAIL wb7_haz_post: got %b exp 0", bus.hazard); end
        n_checks++; if (bus.busy_cnt !== 6'd0) begin n_fail++; $display("FAIL wb7_cnt: got %0d exp 0", bus.busy_cnt); end
        tick();
        n_checks++; if (bus.rso2 !== 32'h55) begin n_fail++; $display("FAIL wb7_data: got %h exp %h", bus.rso2, 32'h55); end
        idle();
        bus.iss_en = 1'b1; bus.iss_rd = 5'd0;
        #1;
        n_checks++; if (bus.hazard !== 1'b0) begin n_fail++; $display("FAIL iss0_haz: got %b exp 0", bus.hazard); end
        tick();
        idle();
        n_checks++; if (bus.busy_cnt !== 6'd0) begin n_fail++; $display("FAIL iss0_cnt: got %0d exp 0", bus.busy_cnt); end
        bus.iss_en = 1'b1; bus.iss_rd = 5'd4;
        tick();
        idle();
        bus.iss_en = 1'b1; bus.iss_rd = 5'd4;
        #1;
        n_checks++; if (bus.hazard !== 1'b1) begin n_fail++; $display("FAIL reiss4_haz: got %b exp 1", bus.hazard); end
        tick();
        idle();
        n_checks++; if (bus.busy_cnt !== 6'd1) begin n_fail++; $display("FAIL reiss4_cnt: got %0d exp 1", bus.busy_cnt); end
        bus.wb_en = 1'b1; bus.wb_reg = 5'd4; bus.wb_val = 32'h4;
        tick();
        idle();
        n_checks++; if (bus.busy_cnt !== 6'd0) begin n_fail++; $display("FAIL wb4_cnt: got %0d exp 0", bus.busy_cnt); end
    endtask

    task automatic test_same_edge();
        idle();
        bus.iss_en = 1'b1; bus.iss_rd = 5'd3;
        tick();
        idle();
        n_checks++; if (bus.busy_cnt !== 6'd1) begin n_fail++; $display("FAIL iss3_cnt: got %0d exp 1", bus.busy_cnt); end
        bus.iss_en = 1'b1; bus.iss_rd = 5'd3;
        bus.wb_en  = 1'b1; bus.wb_reg = 5'd3; bus.wb_val = 32'hA;
        bus.rs1    = 5'd3;
        #1;
        n_checks++; if (bus.hazard !== 1'b1) begin n_fail++; $display("FAIL same3_haz_pre: got %b exp 1", bus.hazard); end
        tick();
        idle();
        n_checks++; if (bus.busy_cnt !== 6'd1) begin n_fail++; $display("FAIL same3_cnt: got %0d exp 1", bus.busy_cnt); end
        bus.rd_en = 1'b1; bus.rs1 = 5'd3;
        #1;
        n_checks++; if (bus.hazard !== 1'b1) begin n_fail++; $display("FAIL same3_busy: got %b exp 1", bus.hazard); end
        tick();
        n_checks++; if (bus.rso1 !== 32'hA) begin n_fail++; $display("FAIL same3_data: got %h exp %h", bus.rso1, 32'hA); end
        idle();
        bus.wb_en = 1'b1; bus.wb_reg = 5'd3; bus.wb_val = 32'hA;
        tick();
        idle();
        n_checks++; if (bus.busy_cnt !== 6'd0) begin n_fail++; $display("FAIL wb3_cnt: got %0d exp 0", bus.busy_cnt); end
        bus.wb_en = 1'b1; bus.wb_reg = 5'd10; bus.wb_val = 32'h99;
        tick();
        idle();
        n_checks++; if (bus.busy_cnt !== 6'd0) begin n_fail++; $display("FAIL nonbusy_wb_cnt: got %0d exp 0", bus.busy_cnt); end
        bus.rd_en = 1'b1; bus.rs1 = 5'd10;
        tick();
        n_checks++; if (bus.rso1 !== 32'h99) begin n_fail++; $display("FAIL nonbusy_wb_data: got %h exp %h", bus.rso1, 32'h99); end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_v;
        idle();
        bus.wb_en = 1'b1; bus.wb_reg = 5'd9; bus.wb_val = 32'h11;
        tick();
        idle();
        bus.rd_en = 1'b1; bus.rs1 = 5'd9;
        tick();
        n_checks++; if (bus.rso1 !== 32'h11) begin n_fail++; $display("FAIL x9_init: got %h exp %h", bus.rso1, 32'h11); end
        idle();
        bus.wb_en = 1'b1; bus.wb_reg = 5'd9; bus.wb_val = 32'h77;
        bus.rd_en = 1'b1; bus.rs1 = 5'd9;
        tick();
        exp_v = BYP ? 32'h77 : 32'h11;
        n_checks++; if (bus.rso1 !== exp_v) begin n_fail++; $display("FAIL same_edge_read: got %h exp %h", bus.rso1, exp_v); end
        idle();
        bus.rd_en = 1'b1; bus.rs1 = 5'd9;
        tick();
        n_checks++; if (bus.rso1 !== 32'h77) begin n_fail++; $display("FAIL x9_after: got %h exp %h", bus.rso1, 32'h77); end
    endtask

    task automatic test_full_and_reset();
        idle();
        for (int r = 1; r < 32; r++) begin
            bus.iss_en = 1'b1; bus.iss_rd = 5'(r);
            tick();
        end
        idle();
        n_checks++; if (bus.busy_cnt !== 6'd31) begin n_fail++; $display("FAIL full_cnt: got %0d exp 31", bus.busy_cnt); end
        bus.iss_en = 1'b1; bus.iss_rd = 5'd0;
        tick();
        idle();
        n_checks++; if (bus.busy_cnt !== 6'd31) begin n_fail++; $display("FAIL full_cnt_hold: got %0d exp 31", bus.busy_cnt); end
        bus.rd_en = 1'b1; bus.rs1 = 5'd5; bus.rs2 = 5'd9;
        tick();
        n_checks++; if (bus.rso1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL pre_rst_rso1: got %h exp %h", bus.rso1, 32'hDEADBEEF); end
        n_checks++; if (bus.rso2 !== 32'h77) begin n_fail++; $display("FAIL pre_rst_rso2: got %h exp %h", bus.rso2, 32'h77); end
        bus.wb_en = 1'b1; bus.wb_reg = 5'd5; bus.wb_val = 32'hFFFFFFFF;
        bus.rs1 = 5'd1;
        #3;
        rst = 1'b0;
        #1;
        n_checks++; if (bus.rso1 !== 32'h0) begin n_fail++; $display("FAIL async_rso1: got %h exp 0", bus.rso1); end
        n_checks++; if (bus.rso2 !== 32'h0) begin n_fail++; $display("FAIL async_rso2: got %h exp 0", bus.rso2); end
        n_checks++; if (bus.busy_cnt !== 6'd0) begin n_fail++; $display("FAIL async_cnt: got %0d exp 0", bus.busy_cnt); end
        n_checks++; if (bus.hazard !== 1'b0) begin n_fail++; $display("FAIL async_hazard: got %b exp 0", bus.hazard); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle();
        bus.rd_en = 1'b1; bus.rs1 = 5'd5; bus.rs2 = 5'd9;
        #1;
        n_checks++; if (bus.hazard !== 1'b0) begin n_fail++; $display("FAIL post_rst_hazard: got %b exp 0", bus.hazard); end
        tick();
        idle();
        n_checks++; if (bus.rso1 !== 32'h0) begin n_fail++; $display("FAIL post_rst_x5: got %h exp 0", bus.rso1); end
        n_checks++; if (bus.rso2 !== 32'h0) begin n_fail++; $display("FAIL post_rst_x9: got %h exp 0", bus.rso2); end
        n_checks++; if (bus.busy_cnt !== 6'd0) begin n_fail++; $display("FAIL post_rst_cnt: got %0d exp 0", bus.busy_cnt); end
    endtask

    // Run all scenarios in order, then report.
    initial begin
        test_reset();
        test_write_read();
        test_scoreboard();
        test_same_edge();
        test_bypass();
        test_full_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32: register data width in bits (legal 8..64).
REQ-002 Parameter NREG, default 32: number of architectural registers, power of two, 4..64. AW = log2(NREG).
REQ-003 Reset is asynchronous and active-low (`rst` low = reset).
REQ-004 Port `clk`, input, 1 bit: single clock; all state changes on the rising edge.
REQ-005 Port `rst`, input, 1 bit: asynchronous active-low reset.
REQ-006 Port `rd_en`, input, 1 bit: when high, capture new read data into `rso1`/`rso2`.
REQ-007 Port `rs1`, input, AW bits: read address, port 1.
REQ-008 Port `rs2`, input, AW bits: read address, port 2.
REQ-009 Port `rso1`, output, XLEN bits: registered read data, port 1.
REQ-010 Port `rso2`, output, XLEN bits: registered read data, port 2.
REQ-011 Port `wb_en`, input, 1 bit: writeback valid.
REQ-012 Port `wb_reg`, input, AW bits: writeback destination.
REQ-013 Port `wb_val`, input, XLEN bits: writeback data.
REQ-014 Port `iss_en`, input, 1 bit: issue valid; marks `iss_rd` pending.
REQ-015 Port `iss_rd`, input, AW bits: destination of the issuing instruction.
REQ-016 Port `hazard`, output, 1 bit: combinational; operand or destination pending.
REQ-017 Port `busy_cnt`, output, AW+1 bits: registered count of pending registers.

Function
REQ-018 Register 0 reads as zero, is never written, and is never marked busy.
REQ-019 Read latency is 1 cycle: when `rd_en`=1 at edge N, `rso1`/`rso2` hold the values of `rs1`/`rs2` sampled at edge N; when `rd_en`=0 the outputs hold.
REQ-020 Write: `wb_en`=1 with `wb_reg`≠0 updates the register at the edge.
REQ-021 Scoreboard: one busy bit per register. `iss_en`=1 with `iss_rd`≠0 sets busy[iss_rd]; `wb_en`=1 clears busy[wb_reg].
REQ-022 When issue and writeback hit the same register in the same cycle, set wins: the bit stays busy and the data is written.
REQ-023 `hazard` = busy[rs1] | busy[rs2] | (`iss_en` & busy[iss_rd]), with register 0 excluded; the bench samples it before the edge.
REQ-024 The module does not block a hazardous issue; the issuer is responsible for honouring `hazard`.
REQ-025 `busy_cnt` equals the population count of the busy bits after each edge; it ranges 0..NREG-1 and never wraps.
REQ-026 A writeback to a non-busy register writes data and leaves `busy_cnt` unchanged.

Reset
REQ-027 While `rst`=0, independent of `clk`: all registers, all busy bits, `rso1`, `rso2` and `busy_cnt` are 0.
REQ-028 While `rst`=0, `hazard` is 0.
REQ-029 The first functional edge is the first rising `clk` after `rst` rises.
REQ-030 Reset asserted mid-operation discards any pending issue or writeback of that cycle.

Configuration
REQ-031 The feature is controlled by the macro REGFILE_SB_BYPASS_EN.
REQ-032 With REGFILE_SB_BYPASS_EN defined, a read capturing a register written at the same edge returns `wb_val` (write-first).
REQ-033 With REGFILE_SB_BYPASS_EN defined, `hazard` ignores busy[wb_reg] when `wb_en`=1 and the issue is not to that register.
REQ-034 With REGFILE_SB_BYPASS_EN undefined, a same-edge read returns the old value (read-first), and `hazard` uses the raw busy bits.

Verification
REQ-035 Scenario: reset, then read all registers → every `rso1`/`rso2` = 0 and `busy_cnt` = 0.
REQ-036 Scenario: write 0xDEADBEEF to x5, read `rs1`=5 next cycle → `rso1` = 0xDEADBEEF; write 0x1234 to x0, read x0 → 0.
REQ-037 Scenario: issue x7, then `rs2`=7 → `hazard`=1 and `busy_cnt`=1; writeback x7 = 0x55 → `hazard`=0 and `busy_cnt`=0.
REQ-038 Scenario: same edge issue x3 and writeback x3 = 0xA → x3 = 0xA, busy[3]=1, `busy_cnt` unchanged from 1.
REQ-039 Scenario: same edge write x9 = 0x77 with `rs1`=9 and `rd_en`=1 → `rso1` = 0x77 with BYPASS_EN, else the prior value.
REQ-040 Scenario: issue x1..x31 → `busy_cnt` = 31; assert `rst` asynchronously mid-clock → all outputs 0 immediately.
